sa_hit_reporter: RTL

- Downstream of the BWT backward-search match stage. Consumes the final suffix-array interval (loc1 = low SA index, loc2 = high SA index) and its completion flag.
- Walks every SA row in the interval through a dedicated suffix-array read port and emits one reference position per hit on a valid/ready stream.
- Throughput is one hit per clock when unstalled. Reports hit count and truncation status.

---
 rtl/sa_hit_reporter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sa_hit_reporter.sv
// Walks a suffix-array interval [lo, hi] through a registered SA read port and
// streams one reference position per hit, capped at MAX_HITS, with count/truncation status.
module sa_hit_reporter #(
    parameter int REF_NUM    = 1024,
    parameter int REF_LENGTH = $clog2(REF_NUM),
    parameter int MAX_HITS   = 16,
    parameter int CNT_W      = $clog2(MAX_HITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [REF_LENGTH-1:0] lo,
    input  logic [REF_LENGTH-1:0] hi,
    output logic                  busy,
    output logic                  sa_rEn,
    output logic [REF_LENGTH-1:0] sa_rAddr,
    input  logic [REF_LENGTH-1:0] sa_rData,
    output logic                  hit_valid,
    input  logic                  hit_ready,
    output logic [REF_LENGTH-1:0] hit_loc,
    output logic                  hit_last,
    output logic                  done,
    output logic [CNT_W-1:0]      hit_count,
    output logic                  truncated
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_EMPTY = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [REF_LENGTH:0] MAX_W = (REF_LENGTH + 1)'(MAX_HITS);

    state_t                state_q, state_d;
    logic [REF_LENGTH-1:0] ptr_q, addr_q;
    logic [CNT_W-1:0]      issue_n_q, issued_q, hit_count_q;
    logic                  trunc_q, inflight_q;
    logic [REF_LENGTH-1:0] fifo_mem [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            fifo_cnt_q;

    logic [REF_LENGTH:0]   n_w;
    logic [CNT_W-1:0]      issue_n_w;
    logic [2:0]            occ;
    logic                  empty_iv, accept, push, pop, issue, last_issue;

    assign n_w       = {1'b0, hi} - {1'b0, lo} + (REF_LENGTH + 1)'(1);
    assign issue_n_w = (n_w > MAX_W) ? CNT_W'(MAX_HITS) : CNT_W'(n_w);
    assign empty_iv  = lo > hi;
    assign accept    = (state_q == S_IDLE) && start;

    assign hit_valid = fifo_cnt_q != 2'd0;
    assign hit_loc   = fifo_mem[rd_ptr_q];
    assign pop       = hit_valid && hit_ready;
    assign push      = inflight_q;

    // Credit counts the slot freed by this cycle's pop, so a steady stream
    // with hit_ready high sustains one read (and one hit) per clock.
    assign occ        = {1'b0, fifo_cnt_q} + {2'b0, inflight_q};
    assign issue      = (state_q == S_READ) && (issued_q != issue_n_q) &&
                        (occ < (3'd2 + {2'b0, pop}));
    assign last_issue = issue && ((issued_q + CNT_W'(1)) == issue_n_q);

    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign sa_rEn    = issue;
    assign sa_rAddr  = issue ? ptr_q : addr_q;
    assign hit_last  = hit_valid && ((hit_count_q + CNT_W'(1)) == issue_n_q);
    assign hit_count = hit_count_q;
    assign truncated = trunc_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = empty_iv ? S_EMPTY : S_READ;
            S_READ:  if (last_issue) state_d = S_DRAIN;
            S_DRAIN: if (!inflight_q &&
                         (fifo_cnt_q == 2'd0 || (fifo_cnt_q == 2'd1 && pop)))
                         state_d = S_DONE;
            S_EMPTY: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            addr_q      <= '0;
            issue_n_q   <= '0;
            issued_q    <= '0;
            hit_count_q <= '0;
            trunc_q     <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (accept) begin
                ptr_q       <= lo;
                issue_n_q   <= empty_iv ? '0 : issue_n_w;
                issued_q    <= '0;
                hit_count_q <= '0;
                trunc_q     <= !empty_iv && (n_w > MAX_W);
            end else begin
                if (issue) begin
                    ptr_q    <= ptr_q + REF_LENGTH'(1);
                    addr_q   <= ptr_q;
                    issued_q <= issued_q + CNT_W'(1);
                end
                if (pop) hit_count_q <= hit_count_q + CNT_W'(1);
            end
        end
    end

    // Two-entry return FIFO; a pending SRAM return is dropped by reset via inflight_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= sa_rData;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

endmodule
